rxdata: RTL

Receive-side counterpart of the hex transmitter: takes the serial line, recovers bytes through an `rxuart` instance, and parses ASCII text of the form `0x` + 1–8 hex digits + terminator into a 32-bit word. Each well-formed number produces a single-cycle `o_stb` with the value on `o_data`. Malformed input produces a single-cycle `o_err`. The block sits between the board's UART RX pin and any command or register logic that wants numeric input from a terminal.

---
 rtl/rxdata_pkg.sv | 30 +++
 rtl/rxdata_rxuart.sv | 114 +++++++++++
 rtl/rxdata.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rxdata_pkg.sv
// Shared definitions for the ASCII hex receive path: FSM encodings and
// the character constants the parser matches against.
package rxdata_pkg;

    // Parser states: waiting for "0", saw "0", saw "x", collecting digits
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ZERO  = 2'd1,
        S_X     = 2'd2,
        S_DIGIT = 2'd3
    } rx_state_t;

    // Byte receiver states: line idle, start bit, data bits, stop bit
    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_t;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_X  = 8'h78;  // lower-case; upper-case folded via | 8'h20
    localparam logic [7:0] CH_CR = 8'h0d;
    localparam logic [7:0] CH_LF = 8'h0a;
    localparam logic [7:0] CH_SP = 8'h20;

    // Longest accepted number: 8 hex digits fill the 32-bit accumulator
    localparam logic [3:0] MAX_DIGITS = 4'd8;

endpackage

// File: rtl/rxdata_rxuart.sv
// 8N1 serial byte receiver. Samples each bit at its centre, using
// UART_SETUP clocks per bit, and emits a one-cycle o_wr with the byte.
// Bytes whose stop bit reads low are dropped.
module rxuart
    import rxdata_pkg::*;
#(
    parameter logic [23:0] UART_SETUP = 24'd868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       o_wr,
    output logic [7:0] o_data
);

    logic        rx_meta_reg, rx_sync_reg;
    uart_state_t state_reg, state_next;
    logic [23:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic        wr_reg, wr_next;
    logic [7:0]  data_reg, data_next;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= U_IDLE;
            baud_cnt_reg <= 24'd0;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'd0;
            wr_reg       <= 1'b0;
            data_reg     <= 8'd0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            wr_reg       <= wr_next;
            data_reg     <= data_next;
        end
    end

    // Bit timing: half a bit to reach the start-bit centre, then full bits
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        wr_next       = 1'b0;
        data_next     = data_reg;
        case (state_reg)
            U_IDLE: begin
                if (!rx_sync_reg) begin
                    baud_cnt_next = {1'b0, UART_SETUP[23:1]};
                    state_next    = U_START;
                end
            end
            U_START: begin
                if (baud_cnt_reg == 24'd0) begin
                    // A glitch that is gone by mid-bit is not a start bit
                    if (!rx_sync_reg) begin
                        baud_cnt_next = UART_SETUP - 24'd1;
                        bit_cnt_next  = 3'd0;
                        state_next    = U_DATA;
                    end else begin
                        state_next = U_IDLE;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg - 24'd1;
                end
            end
            U_DATA: begin
                if (baud_cnt_reg == 24'd0) begin
                    shift_next    = {rx_sync_reg, shift_reg[7:1]};  // LSB first
                    baud_cnt_next = UART_SETUP - 24'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = U_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg - 24'd1;
                end
            end
            U_STOP: begin
                if (baud_cnt_reg == 24'd0) begin
                    if (rx_sync_reg) begin
                        wr_next   = 1'b1;
                        data_next = shift_reg;
                    end
                    state_next = U_IDLE;
                end else begin
                    baud_cnt_next = baud_cnt_reg - 24'd1;
                end
            end
            default: state_next = U_IDLE;
        endcase
    end

    assign o_wr   = wr_reg;
    assign o_data = data_reg;

endmodule

// File: rtl/rxdata.sv
// Serial "0x<hex>" number receiver: recovers bytes from the UART line and
// parses 1-8 hex digits terminated by CR or LF into a 32-bit word.
module rxdata
    import rxdata_pkg::*;
#(
    parameter logic [31:0] UART_SETUP = 32'd868
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_uart_rx,
    output logic        o_stb,
    output logic [31:0] o_data,
    output logic        o_err
);

    logic        rx_wr;
    logic [7:0]  rx_data;
    logic [4:0]  hex;  // {valid, nibble}

    rx_state_t   state_reg, state_next;
    logic [31:0] acc_reg, acc_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] data_reg, data_next;
    logic        stb_reg, stb_next;
    logic        err_reg, err_next;

    // ASCII hex character to {valid, nibble}; letters accepted in either case
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [7:0] lc;
        logic [7:0] v;
        hex_decode = 5'd0;
        lc = c | 8'h20;
        if (c >= 8'h30 && c <= 8'h39) begin
            v = c - 8'h30;
            hex_decode = {1'b1, v[3:0]};
        end else if (lc >= 8'h61 && lc <= 8'h66) begin
            v = lc - 8'h57;
            hex_decode = {1'b1, v[3:0]};
        end
    endfunction

    rxuart #(
        .UART_SETUP(UART_SETUP[23:0])
    ) u_rxuart (
        .clk    (i_clk),
        .reset  (i_reset),
        .rx     (i_uart_rx),
        .o_wr   (rx_wr),
        .o_data (rx_data)
    );

    assign hex = hex_decode(rx_data);

    // Parser state, accumulator and output registers; reset drops any byte in flight
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= S_IDLE;
            acc_reg   <= 32'd0;
            cnt_reg   <= 4'd0;
            data_reg  <= 32'd0;
            stb_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            stb_reg   <= stb_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic; only bytes strobed by the receiver advance the parser
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        stb_next   = 1'b0;
        err_next   = 1'b0;
        if (rx_wr) begin
            case (state_reg)
                S_IDLE: begin
                    // Whitespace between numbers (including the LF of CR/LF) is skipped
                    if (rx_data == CH_0) begin
                        state_next = S_ZERO;
                    end else if (rx_data != CH_CR && rx_data != CH_LF && rx_data != CH_SP) begin
                        err_next = 1'b1;
                    end
                end
                S_ZERO: begin
                    if ((rx_data | 8'h20) == CH_X) begin
                        state_next = S_X;
                    end else begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                S_X: begin
                    if (hex[4]) begin
                        acc_next   = {28'h0, hex[3:0]};
                        cnt_next   = 4'd1;
                        state_next = S_DIGIT;
                    end else begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                S_DIGIT: begin
                    if (hex[4]) begin
                        if (cnt_reg < MAX_DIGITS) begin
                            acc_next = {acc_reg[27:0], hex[3:0]};
                            cnt_next = cnt_reg + 4'd1;
                        end else begin
                            err_next   = 1'b1;
                            state_next = S_IDLE;
                        end
                    end else if (rx_data == CH_CR || rx_data == CH_LF) begin
                        data_next  = acc_reg;
                        stb_next   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign o_stb  = stb_reg;
    assign o_err  = err_reg;
    assign o_data = data_reg;

endmodule
